mux2_sel_sequencer: RTL and testbench
=====================================

Name: mux2_sel_sequencer

Overview:
Controller that sits directly upstream of the 4-bit 2:1 mux. It drives the mux data inputs and select, and samples the mux output.
On a start strobe it latches two operands, then holds select at 0 for DWELL cycles and captures y. It then holds select at 1 for DWELL cycles and captures y again.
It reports done with a self-check error flag, so the mux path can be exercised in-system without a file-driven bench.

Parameters:
WIDTH, 4, data width of mux inputs/output
DWELL, 2, cycles each select value is held before capture; must be >= 1 (elaboration-time error if 0)

Ports:
clk    in   1      clock, all state updates on posedge
rst    in   1      synchronous, active-low reset
start  in   1      begin a sequence; sampled only in IDLE
a_in   in   WIDTH  operand routed to mux input a
b_in   in   WIDTH  operand routed to mux input b
mux_a  out  WIDTH  registered drive to mux a
mux_b  out  WIDTH  registered drive to mux b
mux_s  out  1      registered drive to mux select
mux_y  in   WIDTH  mux output (combinational from mux_a/mux_b/mux_s)
cap_a  out  WIDTH  mux_y captured with mux_s=0
cap_b  out  WIDTH  mux_y captured with mux_s=1
busy   out  1      high in SEL_A and SEL_B
done   out  1      one-cycle pulse, high in DONE
err    out  1      sticky mismatch flag, valid from DONE until next start

Behaviour:
- Reset: rst==0 at posedge forces state IDLE, dwell counter 0. Every output goes to 0: mux_a, mux_b, mux_s, cap_a, cap_b, busy, done, err. Reset has priority over all other events.
- States: IDLE, SEL_A, SEL_B, DONE. All outputs are registered.
- IDLE: if start=1, then mux_a<=a_in, mux_b<=b_in, mux_s<=0, cnt<=0, err<=0, busy<=1, and the next state is SEL_A. Otherwise all outputs hold.
- SEL_A: cnt increments each cycle.
  - When cnt==DWELL-1: cap_a<=mux_y, mux_s<=1, cnt<=0, next state SEL_B.
  - mux_s is therefore 0 for exactly DWELL cycles, and y is sampled on the last of them.
- SEL_B: same counting. When cnt==DWELL-1:
  - cap_b<=mux_y, mux_s<=0, busy<=0, done<=1.
  - err<=(cap_a!=mux_a)|(mux_y!=mux_b).
  - next state DONE.
- DONE: done is high for this single cycle. On the next edge done<=0 and the state returns to IDLE. start is ignored in DONE.
- Latency: with start sampled at edge 0, done is high between edges 2*DWELL and 2*DWELL+1.
  - Minimum start-to-start period is 2*DWELL+2 cycles (4 for DWELL=1, 6 for DWELL=2).
- start, a_in and b_in are ignored while busy or in DONE. mux_a and mux_b stay stable for the whole sequence.
- cap_a, cap_b and err hold their values until the next capture, next start, or reset. cap_a/cap_b are not cleared on start.
- Reset mid-sequence: the state returns to IDLE on that edge and no done pulse is produced. Captured values are cleared.
- mux_s is never toggled outside SEL_A→SEL_B and SEL_B→DONE, and it is 0 whenever the block is idle.
- The dwell counter is sized $clog2(DWELL+1) bits and never exceeds DWELL-1.

Test Plan:
1. rst=0 for 2 cycles with start=1 and random a_in/b_in -> all outputs 0. After release, the state is IDLE and nothing starts until start is sampled with rst=1.
2. DWELL=2, correct mux, a_in=4'b1010, b_in=4'b0101, start pulsed at edge 0:
   - mux_s=0 during edges 0-2, mux_s=1 during edges 2-4.
   - cap_a=1010, cap_b=0101.
   - done high exactly between edges 4 and 5; busy high between edges 0 and 4; err=0.
3. Faulty mux (bench drives mux_y=mux_a constantly), a=4'b1100, b=4'b0011 -> cap_a=1100, cap_b=1100, err=1 with done. err stays 1 until the next start, which clears it.
4. start re-asserted with a_in=4'b1111 while busy -> mux_a keeps the original value, exactly one done pulse, no second sequence.
5. rst=0 asserted during SEL_B -> on that edge busy=0, mux_s=0, cap_a=0, no done pulse. A subsequent start runs a normal sequence.
6. DWELL=1, start held high, a=4'b0001, b=4'b1000 -> done pulses every 4 cycles, cap_a=0001, cap_b=1000, err=0 on every pulse.

Source files
------------

// File: rtl/mux2_sel_sequencer.sv
// Self-test sequencer for a 2:1 mux: drives both data inputs and the select,
// captures y with select=0 and then select=1, and flags a mismatch.
module mux2_sel_sequencer #(
    parameter int WIDTH = 4,
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] mux_a,
    output logic [WIDTH-1:0] mux_b,
    output logic             mux_s,
    input  logic [WIDTH-1:0] mux_y,
    output logic [WIDTH-1:0] cap_a,
    output logic [WIDTH-1:0] cap_b,
    output logic             busy,
    output logic             done,
    output logic             err
);

    generate
        if (DWELL < 1) begin : g_bad_dwell
            $error("mux2_sel_sequencer: DWELL must be >= 1");
        end
    endgenerate

    // Guarded so an illegal DWELL still yields a legal width while the error above fires.
    localparam int CW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL_A = 2'd1,
        SEL_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mux_a     <= '0;
            mux_b     <= '0;
            mux_s     <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mux_a     <= a_in;
                        mux_b     <= b_in;
                        mux_s     <= 1'b0;
                        cnt_reg   <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= SEL_A;
                    end
                end
                SEL_A: begin
                    if (cnt_reg == LAST) begin
                        cap_a     <= mux_y;
                        mux_s     <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= SEL_B;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                SEL_B: begin
                    if (cnt_reg == LAST) begin
                        // cap_a is already stable here, so both halves compare in one edge.
                        cap_b     <= mux_y;
                        mux_s     <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        err       <= (cap_a != mux_a) | (mux_y != mux_b);
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_sel_sequencer.sv
// Randomized bench for mux2_sel_sequencer: two instances (DWELL=2 and DWELL=1)
// with a bench-side mux that can be made faulty, checked against a transaction model.
module tb_mux2_sel_sequencer;

    localparam int D2 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         tests = 0;
    int         fails = 0;

    logic       start2 = 1'b0, start1 = 1'b0;
    logic [3:0] a2 = '0, b2 = '0, a1 = '0, b1 = '0;
    int         mode2 = 0, mode1 = 0;
    logic [3:0] y2, y1;
    logic [3:0] mux_a2, mux_b2, cap_a2, cap_b2, mux_a1, mux_b1, cap_a1, cap_b1;
    logic       mux_s2, busy2, done2, err2, mux_s1, busy1, done1, err1;

    logic [3:0] prev_a = '0, prev_b = '0;
    logic       prev_err = 1'b0;

    always #5 clk = ~clk;

    // Bench-side mux: 0 correct, 1 stuck on a, 2 stuck on b, 3 inverted output.
    function automatic logic [3:0] y_of(input int mode, input logic [3:0] a,
                                        input logic [3:0] b, input logic s);
        case (mode)
            1:       return a;
            2:       return b;
            3:       return ~(s ? b : a);
            default: return s ? b : a;
        endcase
    endfunction

    assign y2 = y_of(mode2, mux_a2, mux_b2, mux_s2);
    assign y1 = y_of(mode1, mux_a1, mux_b1, mux_s1);

    mux2_sel_sequencer #(.WIDTH(4), .DWELL(D2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2),
        .mux_a(mux_a2), .mux_b(mux_b2), .mux_s(mux_s2), .mux_y(y2),
        .cap_a(cap_a2), .cap_b(cap_b2), .busy(busy2), .done(done2), .err(err2)
    );

    mux2_sel_sequencer #(.WIDTH(4), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
        .mux_a(mux_a1), .mux_b(mux_b1), .mux_s(mux_s1), .mux_y(y1),
        .cap_a(cap_a1), .cap_b(cap_b1), .busy(busy1), .done(done1), .err(err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full DWELL=2 transaction; k is the number of edges after the start edge.
    task automatic run_seq(input logic [3:0] a, input logic [3:0] b,
                           input int mode, input bit noise);
        logic [3:0]  ea, eb;
        logic        ee;
        logic [10:0] exp_v;
        logic [8:0]  exp_c;
        ea = y_of(mode, a, b, 1'b0);
        eb = y_of(mode, a, b, 1'b1);
        ee = (ea != a) || (eb != b);
        mode2 = mode; a2 = a; b2 = b; start2 = 1'b1;
        tick();
        for (int k = 0; k <= 2*D2+1; k++) begin
            exp_v = {k < 2*D2, (k >= D2) && (k < 2*D2), k == 2*D2, a, b};
            tests++;
            if ({busy2, mux_s2, done2, mux_a2, mux_b2} !== exp_v) begin
                fails++;
                $display("FAIL seq_ctrl k=%0d got busy/s/done/a/b=%b required %b",
                         k, {busy2, mux_s2, done2, mux_a2, mux_b2}, exp_v);
            end
            exp_c = {(k >= D2) ? ea : prev_a, (k >= 2*D2) ? eb : prev_b,
                     (k >= 2*D2) ? ee : 1'b0};
            tests++;
            if ({cap_a2, cap_b2, err2} !== exp_c) begin
                fails++;
                $display("FAIL seq_cap k=%0d got cap_a/cap_b/err=%b required %b",
                         k, {cap_a2, cap_b2, err2}, exp_c);
            end
            if (k < 2*D2+1) begin
                start2 = noise ? 1'b1 : 1'b0;
                if (noise) begin
                    a2 = 4'hF;
                    b2 = 4'($urandom);
                end
                tick();
            end
        end
        start2 = 1'b0;
        prev_a = ea; prev_b = eb; prev_err = ee;
        $display("[TB] seq a=%b b=%b mode=%0d noise=%0d cap_a=%b cap_b=%b err=%0d",
                 a, b, mode, noise, cap_a2, cap_b2, err2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            tests++;
            if ({busy2, mux_s2, done2, cap_a2, cap_b2, err2} !==
                {3'b000, prev_a, prev_b, prev_err}) begin
                fails++;
                $display("FAIL idle got busy/s/done/cap_a/cap_b/err=%b required %b",
                         {busy2, mux_s2, done2, cap_a2, cap_b2, err2},
                         {3'b000, prev_a, prev_b, prev_err});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start2 = 1'b1; start1 = 1'b1;
        a2 = 4'($urandom); b2 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        tick(); tick();
        tests++;
        if ({mux_a2, mux_b2, mux_s2, cap_a2, cap_b2, busy2, done2, err2} !== 20'd0) begin
            fails++;
            $display("FAIL reset_dut2 got %b required 0",
                     {mux_a2, mux_b2, mux_s2, cap_a2, cap_b2, busy2, done2, err2});
        end
        tests++;
        if ({mux_a1, mux_b1, mux_s1, cap_a1, cap_b1, busy1, done1, err1} !== 20'd0) begin
            fails++;
            $display("FAIL reset_dut1 got %b required 0",
                     {mux_a1, mux_b1, mux_s1, cap_a1, cap_b1, busy1, done1, err1});
        end
        start2 = 1'b0; start1 = 1'b0;
        rst = 1'b1;
        idle(3);
        tests++;
        if ({mux_a2, busy1, mux_a1} !== 9'd0) begin
            fails++;
            $display("FAIL reset_release got mux_a2/busy1/mux_a1=%b required 0",
                     {mux_a2, busy1, mux_a1});
        end
        $display("[TB] reset done");
    endtask

    task automatic test_basic();
        run_seq(4'b1010, 4'b0101, 0, 1'b0);
        idle(2);
    endtask

    task automatic test_fault();
        run_seq(4'b1100, 4'b0011, 1, 1'b0);
        idle(3);
        run_seq(4'b0110, 4'b1001, 0, 1'b0);
        idle(1);
    endtask

    task automatic test_busy_restart();
        run_seq(4'b0011, 4'b1100, 0, 1'b1);
        idle(4);
    endtask

    task automatic test_reset_mid();
        mode2 = 0; a2 = 4'b0110; b2 = 4'b1001; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (D2 + 1) tick();
        tests++;
        if ({busy2, mux_s2} !== 2'b11) begin
            fails++;
            $display("FAIL mid_selb got busy/s=%b required 11", {busy2, mux_s2});
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({busy2, mux_s2, done2, cap_a2, cap_b2, err2} !== 12'd0) begin
            fails++;
            $display("FAIL mid_reset got busy/s/done/cap_a/cap_b/err=%b required 0",
                     {busy2, mux_s2, done2, cap_a2, cap_b2, err2});
        end
        rst = 1'b1;
        prev_a = '0; prev_b = '0; prev_err = 1'b0;
        idle(3);
        run_seq(4'b1110, 4'b0001, 0, 1'b0);
        idle(1);
    endtask

    task automatic test_dwell1_stream();
        mode1 = 0; a1 = 4'b0001; b1 = 4'b1000; start1 = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            tests++;
            if ({done1, busy1} !== {k % 4 == 2, k % 4 < 2}) begin
                fails++;
                $display("FAIL d1_ctrl k=%0d got done/busy=%b required %b",
                         k, {done1, busy1}, {k % 4 == 2, k % 4 < 2});
            end
            if (k % 4 == 2) begin
                tests++;
                if ({cap_a1, cap_b1, err1} !== {4'b0001, 4'b1000, 1'b0}) begin
                    fails++;
                    $display("FAIL d1_cap k=%0d got cap_a/cap_b/err=%b required 000110000",
                             k, {cap_a1, cap_b1, err1});
                end
                $display("[TB] d1 pulse k=%0d cap_a=%b cap_b=%b err=%0d",
                         k, cap_a1, cap_b1, err1);
            end
            tick();
        end
        start1 = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_seq(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fault();
        test_busy_restart();
        test_reset_mid();
        test_dwell1_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
